// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: multi-channel phase-aligned PWM generator.
// One shared period counter drives every channel, so all rising edges line up.
// Period, duty and enable writes land in shadow registers and are applied only
// at a period boundary, which keeps the outputs glitch-free. A write arriving
// in the terminal cycle bypasses the shadow and applies to the very next period.
module servo_pwm_bank #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 20,
  parameter int DEFAULT_PERIOD = 1000000,
  parameter int DEFAULT_DUTY   = 75000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [CNT_W-1:0]        period_in,
  input  logic [NUM_CH*CNT_W-1:0] duty_in,
  input  logic [NUM_CH-1:0]       ch_en_in,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_start,
  output logic                    update_ack,
  output logic                    pending
);

  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  // Shared counter and active/pending period state
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  period_act_q, period_act_d;
  logic [CNT_W-1:0]  period_pend_q;
  logic [CNT_W-1:0]  period_req;
  logic [NUM_CH-1:0] en_act_q, en_act_d;
  logic [NUM_CH-1:0] en_pend_q;
  logic              pending_q, pending_d;

  // Registered outputs
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              period_start_q, period_start_d;
  logic              update_ack_q, update_ack_d;

  // Boundary control
  logic              terminal;
  logic              load_now;

  // Periods below 2 are clamped so the counter always has a real terminal cycle.
  assign period_req = (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in;

  // The terminal test uses >= so that even a corrupted count still wraps
  // instead of running off to the top of the counter range.
  assign terminal = (count_q >= (period_act_q - ONE));

  // New values are loaded at the boundary either from the shadow registers or,
  // when the write coincides with the terminal cycle, straight from the inputs.
  assign load_now = terminal && (wr_en || pending_q);

  // Next-state logic for the shared counter, period, enables and status flags
  always_comb begin
    count_d        = terminal ? '0 : (count_q + ONE);
    period_act_d   = period_act_q;
    en_act_d       = en_act_q;
    pending_d      = pending_q;
    period_start_d = terminal;
    update_ack_d   = load_now;

    if (load_now) begin
      period_act_d = wr_en ? period_req : period_pend_q;
      en_act_d     = wr_en ? ch_en_in : en_pend_q;
    end

    if (terminal) begin
      pending_d = 1'b0;
    end else if (wr_en) begin
      pending_d = 1'b1;
    end
  end

  // Shared state registers with asynchronous reset to the power-on defaults
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q        <= '0;
      period_act_q   <= CNT_W'(DEFAULT_PERIOD);
      en_act_q       <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      update_ack_q   <= 1'b0;
    end else begin
      count_q        <= count_d;
      period_act_q   <= period_act_d;
      en_act_q       <= en_act_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      update_ack_q   <= update_ack_d;
    end
  end

  // Shadow registers capture every write; the last write before a boundary wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_pend_q <= CNT_W'(DEFAULT_PERIOD);
      en_pend_q     <= '0;
    end else if (wr_en) begin
      period_pend_q <= period_req;
      en_pend_q     <= ch_en_in;
    end
  end

  // Per-channel duty storage and compare
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] duty_req;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [CNT_W-1:0] duty_pend_q;

    assign duty_req = duty_in[gi*CNT_W +: CNT_W];

    // Select the duty that becomes active on the next edge
    always_comb begin
      duty_act_d = duty_act_q;
      if (load_now) begin
        duty_act_d = wr_en ? duty_req : duty_pend_q;
      end
    end

    // Active and shadow duty registers for this channel
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        duty_act_q  <= CNT_W'(DEFAULT_DUTY);
        duty_pend_q <= CNT_W'(DEFAULT_DUTY);
      end else begin
        duty_act_q <= duty_act_d;
        if (wr_en) begin
          duty_pend_q <= duty_req;
        end
      end
    end

    // Because count never exceeds period-1, a duty >= period keeps this high
    // for the whole period and a duty of 0 keeps it low.
    assign pwm_d[gi] = en_act_q[gi] && (count_q < duty_act_q);
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign update_ack   = update_ack_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Testbench for servo_pwm_bank (NUM_CH=2, CNT_W=8, DEFAULT_PERIOD=10, DEFAULT_DUTY=3).
// A cycle model pushes the expected outputs of each edge onto a queue that is
// popped and compared after the edge; a vector table plus hand-written
// sequences check measured period length and high times against constants.
module tb_servo_pwm_bank;

  localparam int NCH = 2;
  localparam int CW  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            wr_en = 1'b0;
  logic [CW-1:0]   period_in = '0;
  logic [NCH*CW-1:0] duty_in = '0;
  logic [NCH-1:0]  ch_en_in = '0;
  logic [NCH-1:0]  pwm_out;
  logic            period_start;
  logic            update_ack;
  logic            pending;

  servo_pwm_bank #(
    .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_PERIOD(10), .DEFAULT_DUTY(3)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .period_in(period_in),
    .duty_in(duty_in), .ch_en_in(ch_en_in), .pwm_out(pwm_out),
    .period_start(period_start), .update_ack(update_ack), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] pwm;
    logic       ps;
    logic       ack;
    logic       pend;
  } exp_t;

  typedef struct {
    int         period;
    int         d0;
    int         d1;
    logic [1:0] en;
    int         len;
    int         h0;
    int         h1;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  // Bench-side reference state
  int         m_count, m_period, p_period;
  int         m_duty[NCH];
  int         p_duty[NCH];
  logic [1:0] m_en, p_en;
  bit         m_pend;

  task automatic model_reset();
    m_count = 0; m_period = 10; p_period = 10;
    for (int i = 0; i < NCH; i++) begin m_duty[i] = 3; p_duty[i] = 3; end
    m_en = 2'b00; p_en = 2'b00; m_pend = 0;
  endtask

  task automatic model_step(output exp_t e);
    bit term;
    int cp;
    term = (m_count == m_period - 1);
    for (int i = 0; i < NCH; i++) e.pwm[i] = m_en[i] && (m_count < m_duty[i]);
    e.ps  = term;
    e.ack = term && (m_pend || wr_en);
    cp = (int'(period_in) < 2) ? 2 : int'(period_in);
    if (term) begin
      if (wr_en) begin
        m_period = cp; m_en = ch_en_in;
        for (int i = 0; i < NCH; i++) m_duty[i] = int'(duty_in[i*CW +: CW]);
      end else if (m_pend) begin
        m_period = p_period; m_en = p_en;
        for (int i = 0; i < NCH; i++) m_duty[i] = p_duty[i];
      end
      m_pend = 0;
      m_count = 0;
    end else begin
      m_count++;
      if (wr_en) begin
        p_period = cp; p_en = ch_en_in;
        for (int i = 0; i < NCH; i++) p_duty[i] = int'(duty_in[i*CW +: CW]);
        m_pend = 1;
      end
    end
    e.pend = m_pend;
  endtask

  // One clock: predict, push, clock, pop and compare
  task automatic tick();
    exp_t e, g;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    g = exp_q.pop_front();
    n_vec++;
    if ({pwm_out, period_start, update_ack, pending} !== {g.pwm, g.ps, g.ack, g.pend}) begin
      n_err++;
      $display("FAIL cycle %0d {pwm,period_start,update_ack,pending}: got %b required %b",
               cyc, {pwm_out, period_start, update_ack, pending}, {g.pwm, g.ps, g.ack, g.pend});
    end
    wr_en = 1'b0;
  endtask

  task automatic check(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic do_write(input int p, input int d0, input int d1, input logic [1:0] en);
    period_in = CW'(p);
    duty_in   = {CW'(d1), CW'(d0)};
    ch_en_in  = en;
    wr_en     = 1'b1;
    tick();
  endtask

  task automatic wait_ack(input string name, input int budget);
    int n = 0;
    while (!update_ack && n < budget) begin tick(); n++; end
    check({name, " update_ack seen"}, int'(update_ack), 1);
  endtask

  task automatic wait_ps(input string name, input int budget);
    int n = 0;
    while (!period_start && n < budget) begin tick(); n++; end
    check({name, " period_start seen"}, int'(period_start), 1);
  endtask

  // Starting on a period_start cycle, count cycles and high cycles up to the next one
  task automatic measure(output int len, output int h0, output int h1);
    len = 0; h0 = 0; h1 = 0;
    do begin
      len++;
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      tick();
    end while (!period_start && len < 400);
  endtask

  vec_t vecs[7];

  initial begin
    int len, h0, h1, acks, highs, starts, n;

    vecs[0] = '{period: 10,  d0: 3,   d1: 7,   en: 2'b11, len: 10,  h0: 3,   h1: 7};
    vecs[1] = '{period: 10,  d0: 5,   d1: 7,   en: 2'b11, len: 10,  h0: 5,   h1: 7};
    vecs[2] = '{period: 10,  d0: 0,   d1: 12,  en: 2'b11, len: 10,  h0: 0,   h1: 10};
    vecs[3] = '{period: 1,   d0: 1,   d1: 5,   en: 2'b11, len: 2,   h0: 1,   h1: 2};
    vecs[4] = '{period: 6,   d0: 2,   d1: 4,   en: 2'b01, len: 6,   h0: 2,   h1: 0};
    vecs[5] = '{period: 0,   d0: 0,   d1: 2,   en: 2'b10, len: 2,   h0: 0,   h1: 2};
    vecs[6] = '{period: 255, d0: 100, d1: 254, en: 2'b11, len: 255, h0: 100, h1: 254};

    // Power-on reset: outputs are forced low without any clock edge
    #1 reset = 1'b1;
    #1;
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset period_start", int'(period_start), 0);
    check("reset update_ack", int'(update_ack), 0);
    check("reset pending", int'(pending), 0);
    model_reset();
    @(posedge clk); @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Sequence 1: first write goes pending, loads at the next count 0
    do_write(10, 3, 7, 2'b11);
    check("seq1 pending after write", int'(pending), 1);
    wait_ack("seq1", 20);
    tick();
    wait_ps("seq1", 20);
    measure(len, h0, h1);
    check("seq1 period", len, 10);
    check("seq1 ch0 high", h0, 3);
    check("seq1 ch1 high", h1, 7);
    $display("seq1 write period=10 duty={3,7}: len=%0d h0=%0d h1=%0d", len, h0, h1);

    // Sequence 2: mid-period duty change takes effect next period without a runt
    for (int i = 0; i < 4; i++) tick();
    do_write(10, 5, 7, 2'b11);
    check("seq2 pending mid-period", int'(pending), 1);
    wait_ack("seq2", 20);
    measure(len, h0, h1);
    check("seq2 first period ch0 high", h0, 5);
    check("seq2 first period len", len, 10);
    $display("seq2 mid-period duty0=5: len=%0d h0=%0d", len, h0);

    // Sequence 3: two writes in one period, the last one wins, one ack
    tick(); tick();
    do_write(10, 2, 7, 2'b11);
    tick(); tick();
    do_write(10, 8, 7, 2'b11);
    wait_ack("seq3", 20);
    acks = 0;
    for (int i = 0; i < 20; i++) begin tick(); acks += int'(update_ack); end
    check("seq3 extra acks", acks, 0);
    wait_ps("seq3", 20);
    measure(len, h0, h1);
    check("seq3 ch0 high", h0, 8);
    $display("seq3 two writes 2 then 8: h0=%0d extra_acks=%0d", h0, acks);

    // Sequence 4: write in the terminal cycle bypasses the shadow registers
    n = 0;
    while (m_count != 9 && n < 20) begin tick(); n++; end
    do_write(6, 8, 7, 2'b11);
    check("seq4 update_ack on boundary write", int'(update_ack), 1);
    check("seq4 pending on boundary write", int'(pending), 0);
    measure(len, h0, h1);
    check("seq4 next period len", len, 6);
    $display("seq4 boundary write period=6: len=%0d", len);

    // Vector table: write mid-period, skip the transition period, measure one
    foreach (vecs[k]) begin
      tick(); tick();
      do_write(vecs[k].period, vecs[k].d0, vecs[k].d1, vecs[k].en);
      if (!update_ack) wait_ack("vec", 300);
      tick();
      wait_ps("vec", 300);
      measure(len, h0, h1);
      check($sformatf("vec%0d period", k), len, vecs[k].len);
      check($sformatf("vec%0d ch0 high", k), h0, vecs[k].h0);
      check($sformatf("vec%0d ch1 high", k), h1, vecs[k].h1);
      $display("vec%0d period_in=%0d duty={%0d,%0d} en=%b: len=%0d h0=%0d h1=%0d",
               k, vecs[k].period, vecs[k].d0, vecs[k].d1, vecs[k].en, len, h0, h1);
    end

    // Sequence 6: reset mid-period with a write pending
    do_write(10, 3, 7, 2'b11);
    wait_ack("seq6", 300);
    n = 0;
    while (m_count != 3 && n < 20) begin tick(); n++; end
    do_write(10, 1, 1, 2'b11);
    check("seq6 pending before reset", int'(pending), 1);
    reset = 1'b1;
    #1;
    check("seq6 async pwm_out", int'(pwm_out), 0);
    check("seq6 async period_start", int'(period_start), 0);
    check("seq6 async update_ack", int'(update_ack), 0);
    check("seq6 async pending", int'(pending), 0);
    model_reset();
    exp_q.delete();
    @(posedge clk); @(posedge clk);
    @(negedge clk) reset = 1'b0;
    highs = 0; acks = 0; starts = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      highs  += int'(pwm_out[0]) + int'(pwm_out[1]);
      acks   += int'(update_ack);
      starts += int'(period_start);
    end
    check("seq6 highs after reset", highs, 0);
    check("seq6 acks after reset", acks, 0);
    check("seq6 period_starts in 25 cycles", starts, 2);
    $display("seq6 reset with pending write: highs=%0d acks=%0d starts=%0d", highs, acks, starts);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
